iir_biquad_cascade: RTL and testbench

Parametrised cascade of Direct-Form-I biquad sections for the audio equaliser path. All sections share one time-multiplexed multiplier-accumulator. Coefficients stream into a shadow bank and commit atomically on a sample boundary. Sits between the 24-bit sample source and the output mixer; one instance covers one channel.

---
 rtl/eq_pkg.sv | 23 ++
 rtl/eq_mac_sat.sv | 51 +++++
 rtl/iir_biquad_cascade.sv | 200 ++++++++++++++++++++
 tb/tb_iir_biquad_cascade.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared definitions for the audio equaliser blocks: tap and FSM enums,
// coefficient constants and the saturating clamp used on section outputs.
package eq_pkg;

  localparam int TAPS_PER_SEC  = 5;
  localparam int COEF_FRAC_NOM = 15;
  localparam int UNITY_COEF    = 1 << COEF_FRAC_NOM;

  typedef enum logic [2:0] {TAP_B0, TAP_B1, TAP_B2, TAP_A1, TAP_A2} tap_e;
  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_WB, ST_OUT} state_e;

  // Clamp a sign-extended value into a signed field of width w (2..64).
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/eq_mac_sat.sv
// Registered signed multiply-accumulate with synchronous clear, plus a
// combinational arithmetic-shift-and-saturate view of the accumulator.
module eq_mac_sat
  import eq_pkg::*;
#(
  parameter int A_W   = 17,
  parameter int B_W   = 29,
  parameter int ACC_W = A_W + B_W + 3,
  parameter int FRAC  = 15,
  parameter int OUT_W = 29
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic                    i_sub,
  input  logic signed [A_W-1:0]   i_a,
  input  logic signed [B_W-1:0]   i_b,
  output logic signed [OUT_W-1:0] o_y,
  output logic                    o_ovf
);

  localparam int P_W = A_W + B_W;

  logic signed [P_W-1:0]   w_a_ext;
  logic signed [P_W-1:0]   w_b_ext;
  logic signed [P_W-1:0]   w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_shift;
  logic signed [63:0]      w_wide;
  logic signed [63:0]      w_sat;
  logic signed [ACC_W-1:0] r_acc;

  assign w_a_ext    = {{B_W{i_a[A_W-1]}}, i_a};
  assign w_b_ext    = {{A_W{i_b[B_W-1]}}, i_b};
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_prod_ext = {{(ACC_W - P_W){w_prod[P_W-1]}}, w_prod};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_acc <= '0;
    else if (i_en)    r_acc <= i_sub ? (r_acc - w_prod_ext) : (r_acc + w_prod_ext);
  end

  assign w_shift = r_acc >>> FRAC;
  assign w_wide  = {{(64 - ACC_W){w_shift[ACC_W-1]}}, w_shift};
  assign w_sat   = saturate(w_wide, OUT_W);
  assign o_y     = w_sat[OUT_W-1:0];
  assign o_ovf   = (w_sat != w_wide);

endmodule

// File: rtl/iir_biquad_cascade.sv
// Cascade of Direct-Form-I biquads sharing one MAC, one product per cycle,
// with a shadow coefficient bank committed atomically at a sample boundary.
module iir_biquad_cascade
  import eq_pkg::*;
#(
  parameter int SECTIONS  = 4,
  parameter int DATA_W    = 24,
  parameter int COEF_W    = 17,
  parameter int COEF_FRAC = COEF_FRAC_NOM,
  parameter int OUT_W     = 29,
  parameter int ACC_W     = COEF_W + OUT_W + 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     din_valid,
  input  logic signed [DATA_W-1:0] din,
  output logic                     din_ready,
  input  logic                     coe_valid,
  input  logic signed [COEF_W-1:0] coe,
  output logic                     coe_ready,
  input  logic                     coe_restart,
  output logic                     dout_valid,
  output logic signed [OUT_W-1:0]  dout,
  output logic                     busy,
  output logic                     sat_flag,
  output logic                     drop_flag
);

  localparam int NCOEF  = TAPS_PER_SEC * SECTIONS;
  localparam int SEC_W  = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
  localparam int CIDX_W = $clog2(NCOEF);
  localparam logic signed [COEF_W-1:0] C_UNITY = COEF_W'(1 << COEF_FRAC);

  logic signed [COEF_W-1:0] r_shd [NCOEF];
  logic signed [COEF_W-1:0] r_act [NCOEF];
  logic [CIDX_W-1:0]        r_wcnt;
  logic                     r_pending;

  state_e                   r_state;
  logic [SEC_W-1:0]         r_sec;
  tap_e                     r_tap;
  logic signed [OUT_W-1:0]  r_x0;
  logic signed [OUT_W-1:0]  r_x1 [SECTIONS];
  logic signed [OUT_W-1:0]  r_x2 [SECTIONS];
  logic signed [OUT_W-1:0]  r_y1 [SECTIONS];
  logic signed [OUT_W-1:0]  r_y2 [SECTIONS];
  logic signed [OUT_W-1:0]  r_dout;
  logic                     r_dout_valid;
  logic                     r_sat;
  logic                     r_drop;

  logic                     w_boundary;
  logic                     w_coe_take;
  logic                     w_last_word;
  logic                     w_commit;
  logic                     w_last_sec;
  logic [CIDX_W-1:0]        w_cidx;
  logic signed [OUT_W-1:0]  w_sec_in;
  logic signed [OUT_W-1:0]  w_data;
  logic signed [COEF_W-1:0] w_coef;
  logic                     w_sub;
  logic                     w_mac_clr;
  logic                     w_mac_en;
  logic signed [OUT_W-1:0]  w_y;
  logic                     w_ovf;

  assign din_ready  = (r_state == ST_IDLE) || (r_state == ST_OUT);
  assign busy       = (r_state != ST_IDLE);
  assign coe_ready  = !r_pending;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign sat_flag   = r_sat;
  assign drop_flag  = r_drop;

  // Nothing reads the active bank in IDLE or OUT, so a swap there never splits a sample.
  assign w_boundary  = din_ready;
  assign w_coe_take  = coe_valid && !r_pending && !coe_restart;
  assign w_last_word = w_coe_take && (r_wcnt == CIDX_W'(NCOEF - 1));
  assign w_commit    = w_boundary && (r_pending || w_last_word);

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the banks are small register arrays, so they are reset to pass-through like any flop.
      for (int i = 0; i < NCOEF; i++) begin
        r_shd[i] <= (i % TAPS_PER_SEC == 0) ? C_UNITY : '0;
        r_act[i] <= (i % TAPS_PER_SEC == 0) ? C_UNITY : '0;
      end
      r_wcnt    <= '0;
      r_pending <= 1'b0;
    end else begin
      if (coe_restart) begin
        r_wcnt <= '0;
      end else if (w_coe_take) begin
        r_shd[r_wcnt] <= coe;
        r_wcnt        <= w_last_word ? '0 : r_wcnt + CIDX_W'(1);
      end
      if (w_commit) begin
        for (int i = 0; i < NCOEF; i++) r_act[i] <= r_shd[i];
        if (w_last_word) r_act[NCOEF-1] <= coe;
        r_pending <= 1'b0;
      end else if (w_last_word) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign w_last_sec = (r_sec == SEC_W'(SECTIONS - 1));
  assign w_cidx     = CIDX_W'(r_sec) * CIDX_W'(TAPS_PER_SEC) + CIDX_W'(r_tap);
  assign w_sec_in   = (r_sec == '0) ? r_x0 : r_y1[r_sec - SEC_W'(1)];
  assign w_coef     = r_act[w_cidx];
  assign w_sub      = (r_tap == TAP_A1) || (r_tap == TAP_A2);
  assign w_mac_clr  = (r_state == ST_WB);
  assign w_mac_en   = (r_state == ST_MAC);

  always_comb begin
    // NOTE: default assignment first so no path leaves w_data unassigned and no latch is inferred.
    w_data = w_sec_in;
    case (r_tap)
      TAP_B1:  w_data = r_x1[r_sec];
      TAP_B2:  w_data = r_x2[r_sec];
      TAP_A1:  w_data = r_y1[r_sec];
      TAP_A2:  w_data = r_y2[r_sec];
      default: ;
    endcase
  end

  eq_mac_sat #(
    .A_W   (COEF_W),
    .B_W   (OUT_W),
    .ACC_W (ACC_W),
    .FRAC  (COEF_FRAC),
    .OUT_W (OUT_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_mac_clr),
    .i_en  (w_mac_en),
    .i_sub (w_sub),
    .i_a   (w_coef),
    .i_b   (w_data),
    .o_y   (w_y),
    .o_ovf (w_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sec   <= '0;
      r_tap   <= TAP_B0;
      r_x0    <= '0;
      for (int s = 0; s < SECTIONS; s++) begin
        r_x1[s] <= '0;
        r_x2[s] <= '0;
        r_y1[s] <= '0;
        r_y2[s] <= '0;
      end
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_sat        <= 1'b0;
      r_drop       <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      if (din_valid && !din_ready) r_drop <= 1'b1;
      case (r_state)
        ST_IDLE, ST_OUT: begin
          if (din_valid) begin
            r_x0    <= {{(OUT_W - DATA_W){din[DATA_W-1]}}, din};
            r_sec   <= '0;
            r_tap   <= TAP_B0;
            r_state <= ST_MAC;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_MAC: begin
          if (r_tap == TAP_A2) r_state <= ST_WB;
          else                 r_tap   <= tap_e'(r_tap + 3'd1);
        end
        ST_WB: begin
          r_x2[r_sec] <= r_x1[r_sec];
          r_x1[r_sec] <= w_sec_in;
          r_y2[r_sec] <= r_y1[r_sec];
          r_y1[r_sec] <= w_y;
          if (w_ovf) r_sat <= 1'b1;
          r_tap <= TAP_B0;
          if (w_last_sec) begin
            r_dout       <= w_y;
            r_dout_valid <= 1'b1;
            r_state      <= ST_OUT;
          end else begin
            r_sec   <= r_sec + SEC_W'(1);
            r_state <= ST_MAC;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Directed, table-driven bench for iir_biquad_cascade (4 sections); unused
// sections are left at pass-through so single-section responses are visible.
module tb_iir_biquad_cascade;
  import eq_pkg::*;

  localparam int SECTIONS  = 4;
  localparam int DATA_W    = 24;
  localparam int COEF_W    = 17;
  localparam int COEF_FRAC = 15;
  localparam int OUT_W     = 29;
  localparam int NCOEF     = TAPS_PER_SEC * SECTIONS;
  localparam int LAT       = 6 * SECTIONS + 1;
  localparam longint SAT_MAX = (64'sd1 <<< (OUT_W - 1)) - 1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     din_valid;
  logic signed [DATA_W-1:0] din;
  logic                     din_ready;
  logic                     coe_valid;
  logic signed [COEF_W-1:0] coe;
  logic                     coe_ready;
  logic                     coe_restart;
  logic                     dout_valid;
  logic signed [OUT_W-1:0]  dout;
  logic                     busy;
  logic                     sat_flag;
  logic                     drop_flag;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string name;
    int    din;
    int    exp;
  } vec_t;

  vec_t pt_vecs   [4];
  vec_t gain_vecs [4];
  vec_t fb_vecs   [6];
  logic signed [COEF_W-1:0] coef_set [NCOEF];

  iir_biquad_cascade #(
    .SECTIONS  (SECTIONS),
    .DATA_W    (DATA_W),
    .COEF_W    (COEF_W),
    .COEF_FRAC (COEF_FRAC),
    .OUT_W     (OUT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din_valid   (din_valid),
    .din         (din),
    .din_ready   (din_ready),
    .coe_valid   (coe_valid),
    .coe         (coe),
    .coe_ready   (coe_ready),
    .coe_restart (coe_restart),
    .dout_valid  (dout_valid),
    .dout        (dout),
    .busy        (busy),
    .sat_flag    (sat_flag),
    .drop_flag   (drop_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, required finish before 1000000 time units");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk_vec(input string name, input int d, input int e);
    vec_t v;
    v.name = name;
    v.din  = d;
    v.exp  = e;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    din_valid   = 1'b0;
    coe_valid   = 1'b0;
    coe_restart = 1'b0;
    din         = '0;
    coe         = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Section sec gets {b0, 0, 0, a1, 0}; every other section is pass-through.
  task automatic set_bank(input int sec, input int b0, input int a1);
    for (int i = 0; i < NCOEF; i++)
      coef_set[i] = (i % TAPS_PER_SEC == 0) ? COEF_W'(UNITY_COEF) : '0;
    coef_set[sec * TAPS_PER_SEC]     = COEF_W'(b0);
    coef_set[sec * TAPS_PER_SEC + 3] = COEF_W'(a1);
  endtask

  task automatic load_coefs(input int n);
    int guard;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      while (!coe_ready && guard < 200) begin
        tick();
        guard++;
      end
      if (!coe_ready) check("coe_ready_timeout", coe_ready, 1);
      coe       = coef_set[i];
      coe_valid = 1'b1;
      tick();
      coe_valid = 1'b0;
    end
  endtask

  task automatic wait_dout(inout int lat);
    while (!dout_valid && lat < 200) begin
      tick();
      lat++;
    end
    if (!dout_valid) check("dout_valid_timeout", dout_valid, 1);
  endtask

  task automatic send_sample(input int v, output int y, output int lat);
    int guard = 0;
    while (!din_ready && guard < 200) begin
      tick();
      guard++;
    end
    if (!din_ready) check("din_ready_timeout", din_ready, 1);
    din       = DATA_W'(v);
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    lat       = 1;
    wait_dout(lat);
    y = dout;
  endtask

  task automatic run_vec(input vec_t v);
    int y;
    int lat;
    send_sample(v.din, y, lat);
    check({v.name, "_dout"}, y, v.exp);
    check({v.name, "_lat"}, lat, LAT);
  endtask

  initial begin
    int y;
    int lat;
    int cnt;
    longint exp_sat;

    pt_vecs[0]   = mk_vec("pt_min",  -8388608, -8388608);
    pt_vecs[1]   = mk_vec("pt_max",   8388607,  8388607);
    pt_vecs[2]   = mk_vec("pt_neg1",       -1,       -1);
    pt_vecs[3]   = mk_vec("pt_zero",        0,        0);
    gain_vecs[0] = mk_vec("gain_pos",     1000,      500);
    gain_vecs[1] = mk_vec("gain_negodd", -1001,     -501);
    gain_vecs[2] = mk_vec("gain_max",  8388607,  4194303);
    gain_vecs[3] = mk_vec("gain_min", -8388608, -4194304);
    fb_vecs[0]   = mk_vec("fb_0", 1000, 1000);
    fb_vecs[1]   = mk_vec("fb_1",    0,  500);
    fb_vecs[2]   = mk_vec("fb_2",    0,  250);
    fb_vecs[3]   = mk_vec("fb_3",    0,  125);
    fb_vecs[4]   = mk_vec("fb_4",    0,   62);
    fb_vecs[5]   = mk_vec("fb_5",    0,   31);

    // Reset state
    do_reset();
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_din_ready", din_ready, 1);
    check("rst_coe_ready", coe_ready, 1);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_drop_flag", drop_flag, 0);

    // First pass-through sample with the busy / ready window
    din       = DATA_W'(1000);
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    check("busy_t1", busy, 1);
    check("ready_t1", din_ready, 0);
    lat = 1;
    wait_dout(lat);
    check("pt_first_lat", lat, LAT);
    check("pt_first_dout", dout, 1000);
    check("busy_at_dout", busy, 1);
    check("ready_at_dout", din_ready, 1);
    tick();
    check("busy_after", busy, 0);
    check("dout_valid_pulse", dout_valid, 0);
    check("dout_held", dout, 1000);
    for (int i = 0; i < 4; i++) run_vec(pt_vecs[i]);
    check("pt_sat_flag", sat_flag, 0);

    // Half-gain bank loaded while idle commits immediately
    set_bank(0, 16384, 0);
    load_coefs(NCOEF);
    check("idle_commit_coe_ready", coe_ready, 1);
    for (int i = 0; i < 4; i++) run_vec(gain_vecs[i]);

    // Commit while a sample is in flight; also a dropped sample and a word while pending
    do_reset();
    set_bank(SECTIONS - 1, 16384, 0);
    din       = DATA_W'(1000);
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    lat = 1;
    load_coefs(NCOEF);
    lat += NCOEF;
    check("pending_coe_ready", coe_ready, 0);
    coe       = '0;
    coe_valid = 1'b1;
    tick();
    coe_valid = 1'b0;
    lat++;
    din       = DATA_W'(5000);
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    lat++;
    check("drop_flag_set", drop_flag, 1);
    wait_dout(lat);
    check("inflight_lat", lat, LAT);
    check("inflight_dout", dout, 1000);
    tick();
    check("commit_clears_pending", coe_ready, 1);
    cnt = 0;
    for (int i = 0; i < 2 * LAT; i++) begin
      if (dout_valid) cnt++;
      tick();
    end
    check("dropped_no_dout", cnt, 0);
    check("dropped_dout_unchanged", dout, 1000);
    send_sample(1000, y, lat);
    check("after_commit_dout", y, 500);

    // Restart after 3 words (restart wins over a word in the same cycle)
    do_reset();
    coe = '0;
    for (int i = 0; i < 3; i++) begin
      coe_valid = 1'b1;
      tick();
    end
    coe         = COEF_W'(12345);
    coe_restart = 1'b1;
    tick();
    coe_restart = 1'b0;
    coe_valid   = 1'b0;
    check("restart_coe_ready", coe_ready, 1);
    set_bank(0, 16384, 0);
    load_coefs(NCOEF);
    send_sample(1000, y, lat);
    check("restart_dout", y, 500);

    // Feedback impulse response
    do_reset();
    set_bank(0, 32768, -16384);
    load_coefs(NCOEF);
    for (int i = 0; i < 6; i++) run_vec(fb_vecs[i]);

    // Integrator driven to saturation
    do_reset();
    set_bank(0, 32768, -32768);
    load_coefs(NCOEF);
    for (int n = 1; n <= 34; n++) begin
      send_sample(8388607, y, lat);
      exp_sat = longint'(n) * 64'sd8388607;
      if (exp_sat > SAT_MAX) exp_sat = SAT_MAX;
      check($sformatf("sat_n%0d", n), y, exp_sat);
      if (n == 32) check("sat_flag_n32", sat_flag, 0);
      if (n >= 33) check($sformatf("sat_flag_n%0d", n), sat_flag, 1);
    end

    // Reset in the middle of a computation
    do_reset();
    check("sat_flag_cleared", sat_flag, 0);
    set_bank(0, 32768, -16384);
    load_coefs(NCOEF);
    send_sample(1000, y, lat);
    check("midop_pre_dout", y, 1000);
    din       = '0;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    lat = 1;
    while (lat < 10) begin
      tick();
      lat++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 2 * LAT; i++) begin
      if (dout_valid) cnt++;
      tick();
    end
    check("midop_no_dout_valid", cnt, 0);
    check("midop_dout_zero", dout, 0);
    check("midop_busy", busy, 0);
    check("midop_drop_flag", drop_flag, 0);
    set_bank(0, 32768, -16384);
    load_coefs(NCOEF);
    send_sample(1000, y, lat);
    check("midop_post_dout0", y, 1000);
    send_sample(0, y, lat);
    check("midop_post_dout1", y, 500);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
